// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: the RISC240 ALU opcode encoding.
package alu_arbiter_pkg;

    typedef enum logic [3:0] {
        F_A         = 4'b0000,
        F_A_PLUS_1  = 4'b0001,
        F_A_PLUS_B  = 4'b0010,
        F_A_MINUS_B = 4'b0011,
        F_A_MINUS_1 = 4'b0100,
        F_A_AND_B   = 4'b0101,
        F_A_OR_B    = 4'b0110,
        F_A_NOT     = 4'b0111,
        F_A_XOR_B   = 4'b1000,
        F_A_ASHR    = 4'b1001,
        F_A_LSHR    = 4'b1010,
        F_A_SHL     = 4'b1011,
        F_B         = 4'b1100,
        F_UNDEF     = 4'b1111
    } alu_op_t;

endpackage

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin; otherwise requester 0 has strict priority.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned DW = 16
) (
    input  logic          clock,
    input  logic          reset_L,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  alu_op_t       req_opcode0,
    input  alu_op_t       req_opcode1,
    input  logic [DW-1:0] req_inA0,
    input  logic [DW-1:0] req_inB0,
    input  logic [DW-1:0] req_inA1,
    input  logic [DW-1:0] req_inB1,
    output logic [1:0]    rsp_valid,
    input  logic [1:0]    rsp_ready,
    output logic [DW-1:0] rsp_out,
    output logic [3:0]    rsp_cc,
    output logic [DW-1:0] alu_inA,
    output logic [DW-1:0] alu_inB,
    output alu_op_t       alu_opcode,
    input  logic [DW-1:0] alu_out,
    input  logic [3:0]    alu_cc,
    output logic          busy
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e        state_q, state_d;
    logic          ptr_q;
    logic          gnt;
    logic          accept;
    logic          owner_q;
    alu_op_t       op_q;
    logic [DW-1:0] a_q, b_q;
    logic [DW-1:0] out_q;
    logic [3:0]    cc_q;

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        gnt = ptr_q;
        case (req_valid)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            default: gnt = ptr_q;
        endcase
    end

    assign accept = (state_q == StIdle) && (req_valid != 2'b00);

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic ptr_d;

    assign ptr_d = accept ? ~gnt : ptr_q;

    always_ff @(posedge clock) begin
        if (!reset_L) ptr_q <= 1'b0;
        else          ptr_q <= ptr_d;
    end
`else
    assign ptr_q = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_L) state_q <= StIdle;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (rsp_ready[owner_q]) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        if (accept)             req_ready[gnt]     = 1'b1;
        if (state_q == StResp)  rsp_valid[owner_q] = 1'b1;
        busy = (state_q != StIdle);
    end

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            owner_q <= 1'b0;
            op_q    <= F_A;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            cc_q    <= '0;
        end else begin
            if (accept) begin
                owner_q <= gnt;
                op_q    <= gnt ? req_opcode1 : req_opcode0;
                a_q     <= gnt ? req_inA1    : req_inA0;
                b_q     <= gnt ? req_inB1    : req_inB0;
            end
            if (state_q == StExec) begin
                out_q <= alu_out;
                cc_q  <= alu_cc;
            end
        end
    end

    assign alu_inA    = a_q;
    assign alu_inB    = b_q;
    assign alu_opcode = op_q;
    assign rsp_out    = out_q;
    assign rsp_cc     = cc_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU, reference grant model and scoreboard.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int unsigned DW = 16;

    logic          clock = 1'b0;
    logic          reset_L = 1'b0;
    logic [1:0]    req_valid = 2'b00;
    logic [1:0]    req_ready;
    alu_op_t       req_opcode0 = F_A;
    alu_op_t       req_opcode1 = F_A;
    logic [DW-1:0] req_inA0 = '0, req_inB0 = '0, req_inA1 = '0, req_inB1 = '0;
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready = 2'b00;
    logic [DW-1:0] rsp_out;
    logic [3:0]    rsp_cc;
    logic [DW-1:0] alu_inA, alu_inB;
    alu_op_t       alu_opcode;
    logic [DW-1:0] alu_out;
    logic [3:0]    alu_cc;
    logic          busy;

    alu_arbiter #(.DW(DW)) dut (
        .clock(clock), .reset_L(reset_L),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode0(req_opcode0), .req_opcode1(req_opcode1),
        .req_inA0(req_inA0), .req_inB0(req_inB0), .req_inA1(req_inA1), .req_inB1(req_inB1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out), .rsp_cc(rsp_cc),
        .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_cc(alu_cc), .busy(busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns {Z,C,N,V, result}.
    function automatic logic [DW+3:0] alu_f(input alu_op_t op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        logic [DW:0]   s;
        logic [DW-1:0] r;
        logic          c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            F_A_PLUS_B: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[DW-1:0];
                c = s[DW];
                v = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
            end
            F_A_MINUS_B: begin
                s = {1'b0, a} + {1'b0, ~b} + 17'd1;
                r = s[DW-1:0];
                c = s[DW];
                v = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]);
            end
            F_A_AND_B: r = a & b;
            F_A_OR_B:  r = a | b;
            F_A_XOR_B: r = a ^ b;
            F_B:       r = b;
            default:   r = a;
        endcase
        return {(r == '0), c, r[DW-1], v, r};
    endfunction

    always_comb {alu_cc, alu_out} = alu_f(alu_opcode, alu_inA, alu_inB);

    typedef struct {
        int            owner;
        logic [DW+3:0] res;
        int            acc;
    } item_t;

    item_t sb[$];
    int    glog[$];
    int    gcyc[$];
    int    cyc = 0;
    logic  ptr_m = 1'b0;

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clock) begin : mon
        item_t       f;
        item_t       n;
        logic [1:0]  exp_rv;
        logic [1:0]  exp_rdy;
        int          g;
        cyc++;
        if (!reset_L) begin
            sb.delete();
            ptr_m = 1'b0;
        end else if (sb.size() != 0) begin
            f = sb[0];
            exp_rv = (cyc - f.acc >= 2) ? (2'b01 << f.owner) : 2'b00;
            check_eq("busy_active", busy, 1);
            check_eq("req_ready_active", req_ready, 2'b00);
            check_eq("rsp_valid", rsp_valid, exp_rv);
            if (exp_rv != 2'b00) begin
                check_eq("rsp_out", rsp_out, f.res[DW-1:0]);
                check_eq("rsp_cc", rsp_cc, f.res[DW+3:DW]);
                if ((rsp_ready & exp_rv) != 2'b00) void'(sb.pop_front());
            end
        end else begin
            check_eq("busy_idle", busy, 0);
            check_eq("rsp_valid_idle", rsp_valid, 2'b00);
            case (req_valid)
                2'b01:   g = 0;
                2'b10:   g = 1;
                default: g = int'(ptr_m);
            endcase
            exp_rdy = (req_valid == 2'b00) ? 2'b00 : (2'b01 << g);
            check_eq("req_ready_idle", req_ready, exp_rdy);
            if (req_valid != 2'b00) begin
                n.owner = g;
                n.acc   = cyc;
                n.res   = (g == 0) ? alu_f(req_opcode0, req_inA0, req_inB0)
                                   : alu_f(req_opcode1, req_inA1, req_inB1);
                sb.push_back(n);
                glog.push_back(g);
                gcyc.push_back(cyc);
`ifdef ALU_ARB_ROUND_ROBIN_EN
                ptr_m = (g == 0);
`endif
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int who, input alu_op_t op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b);
        if (who == 0) begin
            req_opcode0 = op; req_inA0 = a; req_inB0 = b;
        end else begin
            req_opcode1 = op; req_inA1 = a; req_inB1 = b;
        end
    endtask

    // Raise one request, wait for its handshake, then drop it and scramble its inputs.
    task automatic issue(input int who, input alu_op_t op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
        logic ok;
        ok = 1'b0;
        set_req(who, op, a, b);
        req_valid[who] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (req_valid[who] && req_ready[who]) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("issue_accept", ok, 1);
        step();
        req_valid[who] = 1'b0;
        set_req(who, alu_op_t'(4'($urandom_range(0, 12))), DW'($urandom), DW'($urandom));
    endtask

    task automatic wait_idle(input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (sb.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check_eq("idle_timeout", done, 1);
        step();
    endtask

    task automatic wait_rsp(input int who);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (rsp_valid[who]) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("rsp_timeout", seen, 1);
    endtask

    logic         rand_rdy = 1'b0;
    always @(posedge clock) begin
        #1;
        if (rand_rdy) rsp_ready = 2'($urandom);
    end

    alu_op_t ops [6] = '{F_A, F_B, F_A_PLUS_B, F_A_MINUS_B, F_A_AND_B, F_A_XOR_B};

    initial begin : stim
        int            base;
        logic          got;
        logic [DW-1:0] hold_out;
        logic [3:0]    hold_cc;

        // Reset values
        repeat (2) step();
        @(negedge clock);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rsp_valid", rsp_valid, 2'b00);
        check_eq("rst_rsp_out", rsp_out, 0);
        check_eq("rst_rsp_cc", rsp_cc, 0);
        check_eq("rst_alu_opcode", alu_opcode, F_A);
        check_eq("rst_alu_inA", alu_inA, 0);
        check_eq("rst_alu_inB", alu_inB, 0);
        step();
        reset_L = 1'b1;
        step();

        // Signed overflow add from requester 0
        rsp_ready = 2'b11;
        issue(0, F_A_PLUS_B, 16'h7FFF, 16'h0001);
        wait_rsp(0);
        check_eq("add_rsp_valid", rsp_valid, 2'b01);
        check_eq("add_rsp_out", rsp_out, 16'h8000);
        check_eq("add_rsp_cc", rsp_cc, 4'b0011);
        wait_idle(20);

        // Zero-result subtract from requester 1
        issue(1, F_A_MINUS_B, 16'h1234, 16'h1234);
        wait_rsp(1);
        check_eq("sub_rsp_valid", rsp_valid, 2'b10);
        check_eq("sub_rsp_out", rsp_out, 16'h0000);
        check_eq("sub_rsp_cc", rsp_cc, 4'b1100);
        wait_idle(20);

        // Both requesters valid continuously
        set_req(0, F_A_PLUS_B, 16'h0100, 16'h0023);
        set_req(1, F_A_XOR_B, 16'hF0F0, 16'h0FF0);
        base = glog.size();
        req_valid = 2'b11;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (glog.size() >= base + 4) break;
        end
        step();
        req_valid = 2'b00;
        check_eq("contend_grants", (glog.size() >= base + 4), 1);
        if (glog.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
                check_eq("contend_owner", glog[base + i], i % 2);
`else
                check_eq("contend_owner", glog[base + i], 0);
`endif
                if (i > 0) check_eq("contend_spacing", gcyc[base + i] - gcyc[base + i - 1], 3);
            end
        end
        wait_idle(20);

        // Response backpressure, non-owner ready ignored, no accept outside IDLE
        rsp_ready = 2'b00;
        issue(0, F_A_MINUS_B, 16'h0005, 16'h0009);
        set_req(1, F_A_PLUS_B, 16'h1111, 16'h2222);
        req_valid = 2'b10;
        rsp_ready = 2'b10;
        wait_rsp(0);
        hold_out = rsp_out;
        hold_cc  = rsp_cc;
        check_eq("bp_rsp_out", hold_out, 16'hFFFC);
        check_eq("bp_rsp_cc", hold_cc, 4'b0010);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_eq("bp_hold_out", rsp_out, hold_out);
            check_eq("bp_hold_cc", rsp_cc, hold_cc);
            check_eq("bp_req_ready", req_ready, 2'b00);
            check_eq("bp_busy", busy, 1);
        end
        step();
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        @(negedge clock);
        @(negedge clock);
        check_eq("bp_release_idle", busy, 0);
        step();
        rsp_ready = 2'b11;

        // Reset while in EXEC abandons the operation
        issue(1, F_A_PLUS_B, 16'h4000, 16'h4000);
        reset_L = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check_eq("exec_rst_rsp_valid", rsp_valid, 2'b00);
        check_eq("exec_rst_busy", busy, 0);
        check_eq("exec_rst_rsp_out", rsp_out, 0);
        step();
        reset_L = 1'b1;
        set_req(0, F_A_AND_B, 16'hFF00, 16'h0FF0);
        set_req(1, F_A_OR_B, 16'h000F, 16'h00F0);
        base = glog.size();
        req_valid = 2'b11;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (glog.size() > base) begin
                got = 1'b1;
                break;
            end
        end
        step();
        req_valid = 2'b00;
        check_eq("post_rst_grant_seen", got, 1);
        if (got) check_eq("post_rst_grant_owner", glog[base], 0);
        wait_idle(20);

        // Randomised traffic with random response backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            issue(int'($urandom_range(0, 1)), ops[$urandom_range(0, 5)], DW'($urandom),
                  DW'($urandom));
        end
        wait_idle(200);
        rand_rdy = 1'b0;
        rsp_ready = 2'b00;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
